// File: rtl/lut_cfg_pkg.sv
// Shared types and constants for the serial LUT configuration writer.
package lut_cfg_pkg;
  localparam int LUT4_INIT_BITS = 16;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/lut_cfg_shifter.sv
// Parallel-load, MSB-first shift register with a bit counter that flags the final shift.
module lut_cfg_shifter #(
  parameter int LUT_BITS = 16
) (
  input  logic                gclk,
  input  logic                grst_n,
  input  logic                load,
  input  logic                en,
  input  logic [LUT_BITS-1:0] data,
  output logic                msb_out,
  output logic                last_bit
);
  localparam int CNT_W = $clog2(LUT_BITS);

  logic [LUT_BITS-1:0] shreg;
  logic [CNT_W-1:0]    bit_cnt;

  assign msb_out  = shreg[LUT_BITS-1];
  assign last_bit = (bit_cnt == CNT_W'(LUT_BITS-1));

  // Zero-fill on shift so the output returns to 0 once a word is fully sent.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= data;
      bit_cnt <= '0;
    end else if (en) begin
      shreg   <= {shreg[LUT_BITS-2:0], 1'b0};
      bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/lut_cfg_writer.sv
// Serial INIT-word writer for a daisy chain of LUTs (CDI/CE), with frame-length checking.
// Optional readback of displaced tail-LUT contents via CDO when LUT_CFG_READBACK_EN is defined.
module lut_cfg_writer
  import lut_cfg_pkg::*;
#(
  parameter int LUT_BITS = LUT4_INIT_BITS,
  parameter int NUM_LUTS = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [LUT_BITS-1:0] IN_DATA,
  input  logic                IN_LAST,
  output logic                CDI,
  output logic                CE,
  input  logic                CDO,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
`ifdef LUT_CFG_READBACK_EN
  ,
  output logic [LUT_BITS-1:0] RDATA,
  output logic                RVALID
`endif
);
  localparam int WC_W = $clog2(NUM_LUTS+1);

  state_t          state_q, state_d;
  logic [WC_W-1:0] word_cnt;
  logic [WC_W:0]   cnt_inc;
  logic            accept, shift_en, last_q, len_bad_q, msb_out, last_bit, frame_end;

  assign accept    = IN_VALID && IN_READY;
  assign shift_en  = (state_q == SHIFT);
  assign cnt_inc   = {1'b0, word_cnt} + (WC_W+1)'(1);
  assign frame_end = shift_en && last_bit && last_q;
  assign CDI       = msb_out;

  lut_cfg_shifter #(.LUT_BITS(LUT_BITS)) u_shifter (
    .gclk     (CLK),
    .grst_n   (RST_N),
    .load     (accept),
    .en       (shift_en),
    .data     (IN_DATA),
    .msb_out  (msb_out),
    .last_bit (last_bit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = last_q ? lut_cfg_pkg::DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake/status outputs are decoded from the next state so they come straight off flops.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      CE       <= 1'b0;
      BUSY     <= 1'b0;
      IN_READY <= 1'b1;
      DONE     <= 1'b0;
    end else begin
      state_q  <= state_d;
      CE       <= (state_d == SHIFT);
      BUSY     <= (state_d != IDLE);
      IN_READY <= (state_d == IDLE);
      DONE     <= (state_d == lut_cfg_pkg::DONE);
    end
  end

  // Overflow flags immediately; a short frame is only known bad when its last word finishes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      word_cnt  <= '0;
      last_q    <= 1'b0;
      len_bad_q <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      if (accept) begin
        last_q    <= IN_LAST;
        len_bad_q <= IN_LAST && (cnt_inc != (WC_W+1)'(NUM_LUTS));
        if (word_cnt != WC_W'(NUM_LUTS)) word_cnt <= cnt_inc[WC_W-1:0];
        if (!IN_LAST && (cnt_inc >= (WC_W+1)'(NUM_LUTS))) ERR <= 1'b1;
        else if (word_cnt == '0)                           ERR <= 1'b0;
      end else if (state_q == lut_cfg_pkg::DONE) begin
        word_cnt <= '0;
      end
      if (frame_end && len_bad_q) ERR <= 1'b1;
    end
  end

`ifdef LUT_CFG_READBACK_EN
  // The tail's old INIT word emerges on CDO MSB-first, one bit per CE cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RDATA  <= '0;
      RVALID <= 1'b0;
    end else begin
      RVALID <= shift_en && last_bit;
      if (CE) RDATA <= {RDATA[LUT_BITS-2:0], CDO};
    end
  end
`else
  logic cdo_unused;
  assign cdo_unused = CDO;
`endif
endmodule
